// File: rtl/tauri_mem_pkg.sv
// Line-fetch constants and responder state encoding shared with the icache controller.
package tauri_mem_pkg;

  localparam int unsigned LINE_BYTES  = 128;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned BEATS       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/imem_line_responder_if.sv
// Icache line-fetch request/response channel plus the external backing-memory read port.
interface imem_line_responder_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 4096
);

  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);

  logic                  icache_a_valid;
  logic                  icache_a_ready;
  logic [ADDR_WIDTH-1:0] icache_a_addr;
  logic                  icache_d_valid;
  logic [WIDTH-1:0]      icache_d_data;
  logic                  mem_rd_en;
  logic [MEM_AW-1:0]     mem_rd_addr;
  logic [WIDTH-1:0]      mem_rd_data;
  logic                  bus_err;

  modport master (
    output icache_a_valid, icache_a_addr, mem_rd_data,
    input  icache_a_ready, icache_d_valid, icache_d_data, mem_rd_en, mem_rd_addr, bus_err
  );

  modport slave (
    input  icache_a_valid, icache_a_addr, mem_rd_data,
    output icache_a_ready, icache_d_valid, icache_d_data, mem_rd_en, mem_rd_addr, bus_err
  );

endinterface

// File: rtl/imem_line_responder.sv
// Serves 128-byte instruction-line fetches as 32 contiguous beats read from an
// external 1-cycle-latency memory; out-of-range lines return zeros and set a sticky error.
module imem_line_responder
  import tauri_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BEATS      = 32,
  parameter int unsigned MEM_WORDS  = 4096
) (
  input logic                  clk,
  input logic                  rst_n,
  imem_line_responder_if.slave bus
);

  localparam int unsigned BEAT_BITS = $clog2(BEATS);
  localparam int unsigned MEM_AW    = $clog2(MEM_WORDS);
  localparam int unsigned LINE_BITS = ADDR_WIDTH - OFFSET_BITS;
  localparam int unsigned WORD_BITS = LINE_BITS + BEAT_BITS;
  localparam int unsigned CMP_BITS  = WORD_BITS + 1;

  state_e               state_q, state_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [WORD_BITS-1:0] base_q, base_d;
  logic [WORD_BITS-1:0] req_base;
  logic                 req_oob;
  logic                 oob_q, oob_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 issue_q, issue_d;
  logic                 rd_en_q, rd_en_d;
  logic [MEM_AW-1:0]    rd_addr_q, rd_addr_d;
  logic                 dvalid_q;
  logic                 dzero_q;
  logic                 unused_addr_bits;

  // Byte offset within the line is irrelevant: a fetch always returns the whole line.
  assign unused_addr_bits = ^bus.icache_a_addr[OFFSET_BITS-1:0];

  assign req_base = {bus.icache_a_addr[ADDR_WIDTH-1:OFFSET_BITS], BEAT_BITS'(0)};
  assign req_oob  = (CMP_BITS'(req_base) + CMP_BITS'(BEATS - 1)) >= CMP_BITS'(MEM_WORDS);

  // Next-state and next-output logic; registered outputs are computed one edge ahead.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    oob_d     = oob_q;
    err_d     = err_q;
    ready_d   = 1'b0;
    issue_d   = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;

    unique case (state_q)
      IDLE: begin
        if (ready_q && bus.icache_a_valid) begin
          state_d   = READ;
          beat_d    = '0;
          base_d    = req_base;
          oob_d     = req_oob;
          err_d     = err_q | req_oob;
          issue_d   = 1'b1;
          rd_en_d   = !req_oob;
          rd_addr_d = MEM_AW'(req_base);
        end
      end
      READ: begin
        if (beat_q == BEAT_BITS'(BEATS - 1)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          // Base is line aligned, so OR-ing the beat index never carries.
          beat_d    = beat_q + BEAT_BITS'(1);
          issue_d   = 1'b1;
          rd_en_d   = !oob_q;
          rd_addr_d = MEM_AW'(base_q | WORD_BITS'(beat_d));
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; d_valid trails the issue slot to line up with memory data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      oob_q     <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      issue_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      dvalid_q  <= 1'b0;
      dzero_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      oob_q     <= oob_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      issue_q   <= issue_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      dvalid_q  <= issue_q;
      dzero_q   <= oob_q;
    end
  end

  assign bus.icache_a_ready = ready_q;
  assign bus.icache_d_valid = dvalid_q;
  assign bus.icache_d_data  = (dvalid_q && !dzero_q) ? bus.mem_rd_data : WIDTH'(0);
  assign bus.mem_rd_en      = rd_en_q;
  assign bus.mem_rd_addr    = rd_addr_q;
  assign bus.bus_err        = err_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder with a 1-cycle-latency memory model.
module tb_imem_line_responder;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned BEATS      = 32;
  localparam int unsigned MEM_WORDS  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  imem_line_responder_if #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) bus ();

  imem_line_responder #(
    .WIDTH     (WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .BEATS     (BEATS),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;
  int idle_bad = 0;
  logic ready_prev = 1'b0;

  int acc_q[$];
  int beat_cyc_q[$];
  logic [31:0] beat_data_q[$];
  int rd_addr_q[$];
  int rise_q[$];

  // Memory word w holds 0xA5A5_0000 | w.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= 32'hA5A5_0000 | 32'(bus.mem_rd_addr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Log handshakes, beats and memory reads; cyc is the number of rising edges so far.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.icache_a_valid && bus.icache_a_ready) acc_q.push_back(cyc + 1);
      if (bus.icache_d_valid) begin
        beat_data_q.push_back(bus.icache_d_data);
        beat_cyc_q.push_back(cyc);
      end else if (bus.icache_d_data != 32'h0) begin
        idle_bad++;
      end
      if (bus.mem_rd_en) rd_addr_q.push_back(int'(bus.mem_rd_addr));
      if (bus.icache_a_ready && !ready_prev) rise_q.push_back(cyc);
      ready_prev = bus.icache_a_ready;
    end else begin
      ready_prev = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_q.delete();
    beat_cyc_q.delete();
    beat_data_q.delete();
    rd_addr_q.delete();
    rise_q.delete();
    idle_bad = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input string tag, input int n);
    int k = 0;
    while (acc_q.size() < n && k < 200) begin
      step(1);
      k++;
    end
    check({tag, "_accept_timeout"}, 64'(k < 200), 64'd1);
  endtask

  task automatic check_data(input string tag, input int start, input int base, input int n, input bit oob);
    for (int i = 0; i < n; i++) begin
      if (start + i < beat_data_q.size())
        check($sformatf("%s_beat%0d", tag, start + i), 64'(beat_data_q[start + i]),
              oob ? 64'd0 : 64'(32'hA5A5_0000 | 32'(base + i)));
    end
  endtask

  task automatic verify_line(input string tag, input int base, input bit oob);
    int acc;
    acc = (acc_q.size() > 0) ? acc_q[0] : -1000;
    check({tag, "_accepts"}, 64'(acc_q.size()), 64'd1);
    check({tag, "_beats"}, 64'(beat_data_q.size()), 64'd32);
    if (beat_cyc_q.size() == 32) begin
      check({tag, "_first_beat_cyc"}, 64'(beat_cyc_q[0] - acc), 64'd1);
      check({tag, "_last_beat_cyc"}, 64'(beat_cyc_q[31] - acc), 64'd32);
    end
    check_data(tag, 0, base, 32, oob);
    check({tag, "_rd_count"}, 64'(rd_addr_q.size()), oob ? 64'd0 : 64'd32);
    for (int i = 0; i < rd_addr_q.size() && i < 32; i++)
      check($sformatf("%s_rd_addr%0d", tag, i), 64'(rd_addr_q[i]), 64'(base + i));
    check({tag, "_ready_rises"}, 64'(rise_q.size()), 64'd1);
    if (rise_q.size() > 0) check({tag, "_ready_rise_cyc"}, 64'(rise_q[0] - acc), 64'd33);
    check({tag, "_idle_data_zero"}, 64'(idle_bad), 64'd0);
  endtask

  task automatic single_line(input string tag, input logic [31:0] addr, input int base, input bit oob);
    clear_logs();
    bus.icache_a_addr  = addr;
    bus.icache_a_valid = 1'b1;
    wait_accepts(tag, 1);
    bus.icache_a_valid = 1'b0;
    step(40);
    verify_line(tag, base, oob);
  endtask

  initial begin
    bus.icache_a_valid = 1'b0;
    bus.icache_a_addr  = 32'h0;

    // Reset values
    step(2);
    @(negedge clk);
    check("rst_ready", 64'(bus.icache_a_ready), 64'd0);
    check("rst_d_valid", 64'(bus.icache_d_valid), 64'd0);
    check("rst_d_data", 64'(bus.icache_d_data), 64'd0);
    check("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_bus_err", 64'(bus.bus_err), 64'd0);
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_edge", 64'(bus.icache_a_ready), 64'd0);
    @(negedge clk);
    check("rel_ready_after_edge", 64'(bus.icache_a_ready), 64'd1);
    step(2);

    single_line("single", 32'h0000_0100, 32'h40, 1'b0);
    single_line("unaligned", 32'h0000_017C, 32'h40, 1'b0);

    // Back-to-back with valid held high
    clear_logs();
    bus.icache_a_addr  = 32'h0000_0000;
    bus.icache_a_valid = 1'b1;
    wait_accepts("b2b_first", 1);
    bus.icache_a_addr = 32'h0000_0080;
    wait_accepts("b2b_second", 2);
    bus.icache_a_valid = 1'b0;
    step(40);
    check("b2b_accepts", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) check("b2b_accept_gap", 64'(acc_q[1] - acc_q[0]), 64'd34);
    check("b2b_beats", 64'(beat_data_q.size()), 64'd64);
    if (beat_cyc_q.size() == 64) check("b2b_beat_gap", 64'(beat_cyc_q[32] - beat_cyc_q[31]), 64'd3);
    check_data("b2b", 0, 0, 64, 1'b0);

    // One-cycle request pulse in the middle of a response is ignored
    clear_logs();
    bus.icache_a_addr  = 32'h0000_0000;
    bus.icache_a_valid = 1'b1;
    wait_accepts("pulse", 1);
    bus.icache_a_valid = 1'b0;
    step(4);
    bus.icache_a_addr  = 32'h0000_0080;
    bus.icache_a_valid = 1'b1;
    step(1);
    bus.icache_a_valid = 1'b0;
    step(40);
    verify_line("pulse", 0, 1'b0);

    // Last line that fits: words 0xFE0..0xFFF
    single_line("top_line", 32'h0000_3F80, 32'hFE0, 1'b0);
    check("top_line_bus_err", 64'(bus.bus_err), 64'd0);

    // First line past the end of memory
    single_line("oob", 32'h0000_4000, 32'h1000, 1'b1);
    check("oob_bus_err", 64'(bus.bus_err), 64'd1);

    single_line("after_oob", 32'h0000_0080, 32'h20, 1'b0);
    check("bus_err_sticky", 64'(bus.bus_err), 64'd1);

    // Reset after ten beats of a line
    clear_logs();
    bus.icache_a_addr  = 32'h0000_0100;
    bus.icache_a_valid = 1'b1;
    wait_accepts("mid_rst", 1);
    bus.icache_a_valid = 1'b0;
    begin
      int k = 0;
      while (beat_data_q.size() < 10 && k < 100) begin
        step(1);
        k++;
      end
      check("mid_rst_beat_timeout", 64'(k < 100), 64'd1);
    end
    check("mid_rst_d_valid_before", 64'(bus.icache_d_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_d_valid", 64'(bus.icache_d_valid), 64'd0);
    check("mid_rst_d_data", 64'(bus.icache_d_data), 64'd0);
    check("mid_rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("mid_rst_ready", 64'(bus.icache_a_ready), 64'd0);
    check("mid_rst_bus_err", 64'(bus.bus_err), 64'd0);
    step(2);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_before_edge", 64'(bus.icache_a_ready), 64'd0);
    @(negedge clk);
    check("mid_rst_ready_after_edge", 64'(bus.icache_a_ready), 64'd1);
    step(40);
    check("mid_rst_beats", 64'(beat_data_q.size()), 64'd10);
    check_data("mid_rst", 0, 32'h40, 10, 1'b0);
    check("mid_rst_idle_data_zero", 64'(idle_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
